pc_sequenciador: RTL and testbench

- Program-counter and sequencing stage directly upstream of the opcode decoder. Holds the PC that addresses instruction memory.
- Consumes the decoder's flow-control outputs (Jump, JumpR, Branch, BifNot, Break, In) together with the ALU Zero flag, and computes the next PC.
- Owns a RUN / WAIT_IN / HALT state machine that stalls the processor for switch input and for Break.
- Emits a commit strobe that gates all architectural writes (register file, HI/LO, memory).

---
 rtl/pc_sequenciador.sv | 129 ++++++++++++
 tb/tb_pc_sequenciador.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequenciador.sv
// Program-counter and sequencing stage ahead of the opcode decoder.
// Holds the instruction-memory PC. It picks the next PC from the decoder's
// flow-control bits, and stalls for switch input (In) or a halt (Break).
// The commit strobe gates every architectural write.
//
// state   | meaning
// --------+-------------------------------------------------------------
// RUN     | one instruction per cycle, commit unless Break/In
// WAIT_IN | In instruction held at the decoder until in_confirm rises
// HALT    | stopped on a Break instruction until resume rises
module pc_sequenciador #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int IMM_W  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              Jump,
  input  logic              JumpR,
  input  logic              Branch,
  input  logic              BifNot,
  input  logic              Break,
  input  logic              In,
  input  logic              Zero,
  input  logic [IMM_W-1:0]  imm,
  input  logic [25:0]       jump_target,
  input  logic [DATA_W-1:0] reg_target,
  input  logic              in_confirm,
  input  logic              resume,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus1,
  output logic              commit,
  output logic              waiting_input,
  output logic              halted
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'b00,
    ST_WAIT_IN = 2'b01,
    ST_HALT    = 2'b10
  } state_t;

  localparam int EXT_W = (ADDR_W > IMM_W) ? ADDR_W : IMM_W;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] pc_nxt;
  logic [ADDR_W-1:0] run_target;
  logic [ADDR_W-1:0] br_target;
  logic [EXT_W-1:0]  imm_ext;
  logic              confirm_q, resume_q;
  logic              rise_c, rise_r;
  logic              taken;
  logic              unused_hi;

  // Only the low ADDR_W bits of the wide targets address instruction memory.
  assign unused_hi = ^{jump_target[25:ADDR_W], reg_target[DATA_W-1:ADDR_W],
                       imm_ext[EXT_W-1:ADDR_W]};

  assign pc_plus1 = pc + ADDR_W'(1);
  assign imm_ext  = EXT_W'($signed(imm));
  assign br_target = pc_plus1 + imm_ext[ADDR_W-1:0];
  assign taken    = (Branch & Zero) | (BifNot & ~Zero);

  // Buttons must be released and pressed again, so only rising edges count.
  assign rise_c = in_confirm & ~confirm_q;
  assign rise_r = resume & ~resume_q;

  // Next PC for a retiring RUN instruction, highest priority first.
  always_comb begin
    run_target = pc_plus1;
    if (Jump && JumpR)  run_target = reg_target[ADDR_W-1:0];
    else if (Jump)      run_target = jump_target[ADDR_W-1:0];
    else if (taken)     run_target = br_target;
  end

  // State register, PC and button history; reset wins over everything.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_RUN;
      pc        <= '0;
      confirm_q <= 1'b0;
      resume_q  <= 1'b0;
    end else begin
      state     <= state_nxt;
      pc        <= pc_nxt;
      confirm_q <= in_confirm;
      resume_q  <= resume;
    end
  end

  // Next-state, PC update and status decode, no added latency.
  always_comb begin
    state_nxt     = state;
    pc_nxt        = pc;
    commit        = 1'b0;
    waiting_input = 1'b0;
    halted        = 1'b0;
    case (state)
      ST_RUN: begin
        if (Break) begin
          state_nxt = ST_HALT;
        end else if (In) begin
          state_nxt = ST_WAIT_IN;
        end else begin
          commit = 1'b1;
          pc_nxt = run_target;
        end
      end
      ST_WAIT_IN: begin
        waiting_input = 1'b1;
        if (rise_c) begin
          commit    = 1'b1;
          pc_nxt    = pc_plus1;
          state_nxt = ST_RUN;
        end
      end
      ST_HALT: begin
        halted = 1'b1;
        // The Break itself never retires; execution resumes after it.
        if (rise_r) begin
          pc_nxt    = pc_plus1;
          state_nxt = ST_RUN;
        end
      end
      default: state_nxt = ST_RUN;
    endcase
  end

endmodule

// File: tb/tb_pc_sequenciador.sv
// Scoreboard bench for pc_sequenciador: the stimulus side pushes expected
// per-cycle outputs from a behavioural model, a negedge monitor pops them.
module tb_pc_sequenciador;

  logic        clk;
  logic        reset;
  logic        Jump, JumpR, Branch, BifNot, Break, In, Zero;
  logic [15:0] imm;
  logic [25:0] jump_target;
  logic [31:0] reg_target;
  logic        in_confirm, resume;
  logic [9:0]  pc, pc_plus1;
  logic        commit, waiting_input, halted;

  int errors = 0;
  int checks = 0;

  typedef struct {
    bit         chk;
    logic [9:0] pc;
    logic [9:0] pc1;
    logic       commit;
    logic       wait_in;
    logic       halt;
  } exp_t;

  exp_t exp_q[$];

  // model: mode 0 = running, 1 = waiting for input, 2 = halted
  int m_pc;
  int m_mode;
  bit m_conf_q, m_res_q;

  pc_sequenciador #(.ADDR_W(10), .DATA_W(32), .IMM_W(16)) dut (
    .clock(clk), .reset(reset), .Jump(Jump), .JumpR(JumpR),
    .Branch(Branch), .BifNot(BifNot), .Break(Break), .In(In), .Zero(Zero),
    .imm(imm), .jump_target(jump_target), .reg_target(reg_target),
    .in_confirm(in_confirm), .resume(resume), .pc(pc), .pc_plus1(pc_plus1),
    .commit(commit), .waiting_input(waiting_input), .halted(halted)
  );

  initial begin
    clk = 1'b1;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL timeout: run did not finish (actual=running, required=done)");
    $fatal(1, "timeout");
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
    end
  endtask

  // Monitor: every cycle the DUT presents a full status word.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (e.chk) begin
        chk("pc", {22'd0, pc}, {22'd0, e.pc});
        chk("pc_plus1", {22'd0, pc_plus1}, {22'd0, e.pc1});
        chk("commit", {31'd0, commit}, {31'd0, e.commit});
        chk("waiting_input", {31'd0, waiting_input}, {31'd0, e.wait_in});
        chk("halted", {31'd0, halted}, {31'd0, e.halt});
      end
    end
  end

  function automatic int model_target();
    if (Jump && JumpR) return int'(reg_target) & 1023;
    if (Jump)          return int'(jump_target) & 1023;
    if ((Branch && Zero) || (BifNot && !Zero))
      return (m_pc + 1 + int'($signed(imm))) & 1023;
    return (m_pc + 1) & 1023;
  endfunction

  // Push the expected outputs for the inputs now applied, advance the model,
  // then move to just after the next rising edge.
  task automatic tick();
    exp_t e;
    bit rc, rr;
    rc = in_confirm && !m_conf_q;
    rr = resume && !m_res_q;
    e.chk     = !reset;
    e.pc      = m_pc[9:0];
    e.pc1     = 10'((m_pc + 1) & 1023);
    e.wait_in = (m_mode == 1);
    e.halt    = (m_mode == 2);
    e.commit  = (m_mode == 0) ? (!Break && !In) : (m_mode == 1) ? rc : 1'b0;
    exp_q.push_back(e);
    if (reset) begin
      m_pc = 0; m_mode = 0; m_conf_q = 0; m_res_q = 0;
    end else begin
      case (m_mode)
        0: if (Break) m_mode = 2;
           else if (In) m_mode = 1;
           else m_pc = model_target();
        1: if (rc) begin m_pc = (m_pc + 1) & 1023; m_mode = 0; end
        default: if (rr) begin m_pc = (m_pc + 1) & 1023; m_mode = 0; end
      endcase
      m_conf_q = in_confirm;
      m_res_q  = resume;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear();
    Jump = 0; JumpR = 0; Branch = 0; BifNot = 0; Break = 0; In = 0; Zero = 0;
    imm = '0; jump_target = '0; reg_target = '0;
  endtask

  task automatic jump_to(int a);
    clear();
    Jump = 1; jump_target = 26'(a);
    tick();
    clear();
  endtask

  initial begin
    m_pc = 0; m_mode = 0; m_conf_q = 0; m_res_q = 0;
    clear();
    in_confirm = 0; resume = 0;
    reset = 1;
    tick(); tick();
    reset = 0;

    // sequential run from reset
    repeat (6) tick();

    // conditional branches
    jump_to(10);
    Branch = 1; Zero = 1; imm = 16'hFFFD; tick(); clear();
    jump_to(10);
    Branch = 1; Zero = 0; imm = 16'hFFFD; tick(); clear();
    jump_to(8);
    BifNot = 1; Zero = 0; imm = 16'd4; tick(); clear();
    tick();

    // jumps and PC wrap
    jump_to(3);
    Jump = 1; jump_target = 26'h3FF05; tick(); clear();
    Jump = 1; JumpR = 1; reg_target = 32'hFFFF_F012; jump_target = 26'h155; tick(); clear();
    jump_to(10'h3FF);
    tick(); tick();

    // switch input with the button already held on entry
    in_confirm = 1;
    jump_to(7);
    In = 1;
    repeat (21) tick();
    in_confirm = 0; tick();
    in_confirm = 1; tick();
    clear(); tick();
    in_confirm = 0; tick();

    // break and resume
    jump_to(20);
    Break = 1;
    repeat (5) tick();
    resume = 1; tick();
    clear(); tick();
    resume = 0; tick();

    // reset while waiting, then Break beats In
    jump_to(40);
    In = 1; tick(); tick();
    reset = 1; tick();
    reset = 0; clear(); tick();
    Break = 1; In = 1; tick(); tick();
    clear(); resume = 1; tick();
    resume = 0; tick();

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      Jump        = ($urandom_range(0, 9) == 0);
      JumpR       = $urandom_range(0, 1);
      Branch      = ($urandom_range(0, 6) == 0);
      BifNot      = ($urandom_range(0, 6) == 0);
      Break       = ($urandom_range(0, 49) == 0);
      In          = ($urandom_range(0, 29) == 0);
      Zero        = $urandom_range(0, 1);
      imm         = 16'($urandom);
      jump_target = 26'($urandom);
      reg_target  = $urandom;
      if ($urandom_range(0, 4) == 0) in_confirm = ~in_confirm;
      if ($urandom_range(0, 4) == 0) resume = ~resume;
      reset       = ($urandom_range(0, 199) == 0);
      tick();
    end
    reset = 0;
    clear();
    tick();

    @(negedge clk);
    #1;
    chk("scoreboard_drain", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
